// File: rtl/activation_unit_pkg.sv
// Shared definitions for the activation stage: mode encodings and default lane width.
package activation_unit_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned MODE_W         = 2;

  // Activation select carried alongside each beat
  typedef enum logic [MODE_W-1:0] {
    ACT_RELU   = 2'd0,
    ACT_LEAKY  = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_BYPASS = 2'd3
  } act_mode_e;

  // Width needed to hold a count in 0..n
  function automatic int unsigned count_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= n) w++;
    return w;
  endfunction

endpackage

// File: rtl/activation_lane.sv
// Single-lane activation function, purely combinational.
// Ports:
//   i_x          signed lane value (two's complement)
//   i_mode       activation select
//   i_clip_max   clipped-ReLU ceiling, interpreted as non-negative
//   o_y_c        activated lane value
//   o_is_zero_c  high when o_y_c is zero
module activation_lane
  import activation_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic [DATA_W-1:0] i_x,
  input  act_mode_e         i_mode,
  input  logic [DATA_W-1:0] i_clip_max,
  output logic [DATA_W-1:0] o_y_c,
  output logic              o_is_zero_c
);

  logic              w_neg;
  logic [DATA_W-1:0] w_leak;
  logic              w_above_clip;

  assign w_neg  = i_x[DATA_W-1];

  // Arithmetic shift rounds toward -inf, so small negatives settle at -1
  assign w_leak = DATA_W'($signed(i_x) >>> LEAK_SHIFT);

  // One extra bit so a ceiling with its MSB set still reads as a large positive
  assign w_above_clip = $signed({i_x[DATA_W-1], i_x}) > $signed({1'b0, i_clip_max});

  // Lane function select
  always_comb begin
    o_y_c = i_x;
    case (i_mode)
      ACT_RELU: begin
        if (w_neg) o_y_c = '0;
      end
      ACT_LEAKY: begin
        if (w_neg) o_y_c = w_leak;
      end
      ACT_CLIP: begin
        if (w_neg)             o_y_c = '0;
        else if (w_above_clip) o_y_c = i_clip_max;
      end
      ACT_BYPASS: begin
        o_y_c = i_x;
      end
    endcase
  end

  assign o_is_zero_c = (o_y_c == '0);

endmodule

// File: rtl/activation_unit.sv
// Multi-channel activation stage: 2-stage valid/ready pipeline applying
// ReLU / leaky / clipped / bypass per lane, plus a saturating count of
// zero-valued lanes delivered downstream.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   mode, clip_max    activation controls, captured with each accepted beat
//   in_valid/in_ready input handshake (in_ready is combinational from out_ready)
//   in_data           CHANNELS lanes, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready output handshake
//   out_data          activated lanes, same packing
//   clear_stats       synchronous clear of zero_count
//   zero_count        saturating count of zero lanes delivered
module activation_unit
  import activation_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [MODE_W-1:0]            mode,
  input  logic [DATA_W-1:0]            clip_max,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  input  logic                         clear_stats,
  output logic [CNT_W-1:0]             zero_count
);

  localparam int unsigned BUS_W = CHANNELS * DATA_W;
  localparam int unsigned ZW    = count_width(CHANNELS);

  // Stage 1: captured input beat
  logic              r_s1_valid;
  logic [BUS_W-1:0]  r_s1_data;
  act_mode_e         r_s1_mode;
  logic [DATA_W-1:0] r_s1_clip;

  // Stage 2: activated beat and its zero-lane tally
  logic              r_s2_valid;
  logic [BUS_W-1:0]  r_s2_data;
  logic [ZW-1:0]     r_s2_zeros;

  logic [CNT_W-1:0]  r_zero_count;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_out_hs;
  logic [BUS_W-1:0]  w_act_data;
  logic [CHANNELS-1:0] w_lane_zero;
  logic [ZW-1:0]     w_s1_zeros;
  logic [ZW-1:0]     w_inc;
  logic [CNT_W:0]    w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;

  // Backpressure chain; no skid buffer so in_ready follows out_ready directly
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_s2_valid && out_ready;

  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign zero_count = r_zero_count;

  // One activation lane per channel
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    activation_lane #(
      .DATA_W     (DATA_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .i_x         (r_s1_data[g*DATA_W +: DATA_W]),
      .i_mode      (r_s1_mode),
      .i_clip_max  (r_s1_clip),
      .o_y_c       (w_act_data[g*DATA_W +: DATA_W]),
      .o_is_zero_c (w_lane_zero[g])
    );
  end

  // Count zero lanes of the beat about to enter stage 2
  always_comb begin
    w_s1_zeros = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_s1_zeros = w_s1_zeros + ZW'(w_lane_zero[i]);
    end
  end

  // Stage 1 register: loads only on an input handshake, otherwise holds
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= ACT_RELU;
      r_s1_clip  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_mode <= act_mode_e'(mode);
        r_s1_clip <= clip_max;
      end
    end
  end

  // Stage 2 register: holds data and valid while downstream stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zeros <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data  <= w_act_data;
        r_s2_zeros <= w_s1_zeros;
      end
    end
  end

  // Saturating zero counter; clear keeps the concurrent beat's contribution
  assign w_inc     = w_out_hs ? r_s2_zeros : '0;
  assign w_cnt_sum = {1'b0, r_zero_count} + (CNT_W+1)'(w_inc);

  always_comb begin
    w_cnt_next = w_cnt_sum[CNT_W-1:0];
    if (w_cnt_sum[CNT_W]) w_cnt_next = '1;
    if (clear_stats)      w_cnt_next = CNT_W'(w_inc);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_zero_count <= '0;
    else        r_zero_count <= w_cnt_next;
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit (DATA_W=16, CHANNELS=4, LEAK_SHIFT=3, CNT_W=16).
module tb_activation_unit;

  localparam int unsigned DW = 16;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;

  logic                clock;
  logic                reset;
  logic [1:0]          mode;
  logic [DW-1:0]       clip_max;
  logic                in_valid;
  logic                in_ready;
  logic [CH*DW-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [CH*DW-1:0]    out_data;
  logic                clear_stats;
  logic [CW-1:0]       zero_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Stream table for the backpressure scenario
  logic [63:0] s_din  [6];
  logic [63:0] s_dexp [6];
  logic [1:0]  s_mode [6];
  logic [15:0] s_clip [6];

  activation_unit #(
    .DATA_W     (DW),
    .CHANNELS   (CH),
    .LEAK_SHIFT (3),
    .CNT_W      (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .clip_max    (clip_max),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .clear_stats (clear_stats),
    .zero_count  (zero_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One beat through an idle pipe; controls are scrambled after acceptance
  task automatic single_beat(input string tag, input logic [1:0] m, input logic [15:0] clip,
                             input logic [63:0] din, input logic [63:0] dexp);
    mode      = m;
    clip_max  = clip;
    in_data   = din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    mode     = ~m;
    clip_max = 16'h0000;
    in_data  = 64'hDEAD_BEEF_CAFE_F00D;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, dexp);
    step();
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          in_idx;
    int          out_idx;
    logic        in_hs;
    logic        out_hs;
    logic        stalled;
    logic [63:0] seen_data;

    reset       = 1'b0;
    mode        = 2'd0;
    clip_max    = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    clear_stats = 1'b0;

    s_din[0] = pack4(16'hFFF0, 16'h0010, 16'hFF00, 16'h0001); s_mode[0] = 2'd0; s_clip[0] = 16'h0000;
    s_dexp[0] = pack4(16'h0000, 16'h0010, 16'h0000, 16'h0001);
    s_din[1] = pack4(16'hFFF0, 16'h0010, 16'hFF00, 16'h0001); s_mode[1] = 2'd1; s_clip[1] = 16'h0000;
    s_dexp[1] = pack4(16'hFFFE, 16'h0010, 16'hFFE0, 16'h0001);
    s_din[2] = pack4(16'hFFF8, 16'h0020, 16'h0000, 16'h7FFF); s_mode[2] = 2'd0; s_clip[2] = 16'h0000;
    s_dexp[2] = pack4(16'h0000, 16'h0020, 16'h0000, 16'h7FFF);
    s_din[3] = pack4(16'hFFF8, 16'h0020, 16'h0000, 16'h7FFF); s_mode[3] = 2'd1; s_clip[3] = 16'h0000;
    s_dexp[3] = pack4(16'hFFFF, 16'h0020, 16'h0000, 16'h7FFF);
    s_din[4] = pack4(16'h0200, 16'h00FF, 16'h8000, 16'h0100); s_mode[4] = 2'd2; s_clip[4] = 16'h0100;
    s_dexp[4] = pack4(16'h0100, 16'h00FF, 16'h0000, 16'h0100);
    s_din[5] = pack4(16'h8000, 16'hFFFF, 16'h0000, 16'h1234); s_mode[5] = 2'd3; s_clip[5] = 16'h0000;
    s_dexp[5] = pack4(16'h8000, 16'hFFFF, 16'h0000, 16'h1234);

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_zero_count", 64'(zero_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    step();

    // 1: ReLU
    single_beat("t1_relu", 2'd0, 16'h0000,
                pack4(16'h8000, 16'hFFFF, 16'h0000, 16'h1234),
                pack4(16'h0000, 16'h0000, 16'h0000, 16'h1234));
    check("t1_zero_count", 64'(zero_count), 64'd3);

    // 2: leaky
    single_beat("t2_leaky", 2'd1, 16'h0000,
                pack4(16'hFFF8, 16'hFFFF, 16'hFF00, 16'h0010),
                pack4(16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h0010));
    check("t2_zero_count", 64'(zero_count), 64'd3);

    // 3: clipped, including equality with the ceiling
    single_beat("t3_clip", 2'd2, 16'h0600,
                pack4(16'h0700, 16'h0600, 16'hF000, 16'h0005),
                pack4(16'h0600, 16'h0600, 16'h0000, 16'h0005));
    check("t3_zero_count", 64'(zero_count), 64'd4);

    // 3b: ceiling with MSB set is a large positive, not a negative
    single_beat("t3b_clip_msb", 2'd2, 16'hFFFF,
                pack4(16'h7FFF, 16'h0001, 16'hFFFF, 16'h0000),
                pack4(16'h7FFF, 16'h0001, 16'h0000, 16'h0000));
    check("t3b_zero_count", 64'(zero_count), 64'd6);

    // 4: six-beat stream, per-beat modes, out_ready low for three cycles
    in_idx  = 0;
    out_idx = 0;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (in_idx < 6) begin
        in_valid = 1'b1;
        in_data  = s_din[in_idx];
        mode     = s_mode[in_idx];
        clip_max = s_clip[in_idx];
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      #1;
      if (c >= 3 && c <= 5) check("t4_in_ready_stall", 64'(in_ready), 64'd0);
      in_hs     = in_valid && in_ready;
      out_hs    = out_valid && out_ready;
      stalled   = out_valid && !out_ready;
      seen_data = out_data;
      step();
      if (in_hs) in_idx++;
      if (out_hs) begin
        check("t4_out_data", seen_data, s_dexp[out_idx]);
        out_idx++;
      end
      if (stalled) begin
        check("t4_hold_valid", 64'(out_valid), 64'd1);
        check("t4_hold_data", out_data, seen_data);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4_beats_in", 64'(in_idx), 64'd6);
    check("t4_beats_out", 64'(out_idx), 64'd6);
    step();
    check("t4_no_extra_beat", 64'(out_valid), 64'd0);
    check("t4_zero_count", 64'(zero_count), 64'd13);

    // 5: saturation, then clear concurrent with a handshake
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("t5_clear_idle", 64'(zero_count), 64'd0);
    mode     = 2'd3;
    in_data  = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 16383; k++) step();
    in_valid = 1'b0;
    step();
    step();
    check("t5_pre_sat", 64'(zero_count), 64'hFFFC);
    single_beat("t5_sat_beat", 2'd0, 16'h0000, 64'd0, 64'd0);
    check("t5_saturate", 64'(zero_count), 64'hFFFF);
    single_beat("t5_sat_again", 2'd0, 16'h0000, 64'd0, 64'd0);
    check("t5_stay_sat", 64'(zero_count), 64'hFFFF);
    mode      = 2'd3;
    in_data   = pack4(16'h0000, 16'h0000, 16'h0005, 16'h0005);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("t5_staged_valid", 64'(out_valid), 64'd1);
    step();
    check("t5_stall_valid", 64'(out_valid), 64'd1);
    check("t5_stall_data", out_data, pack4(16'h0000, 16'h0000, 16'h0005, 16'h0005));
    check("t5_stall_count", 64'(zero_count), 64'hFFFF);
    out_ready   = 1'b1;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("t5_clear_with_beat", 64'(zero_count), 64'd2);
    check("t5_drained", 64'(out_valid), 64'd0);

    // 6: asynchronous reset with both stages full
    out_ready = 1'b0;
    mode      = 2'd3;
    in_data   = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    in_valid  = 1'b1;
    step();
    in_data = pack4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    step();
    in_valid = 1'b0;
    check("t6_full_valid", 64'(out_valid), 64'd1);
    check("t6_full_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_out_data", out_data, 64'd0);
    check("t6_rst_zero_count", 64'(zero_count), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    check("t6_no_stale_beat", 64'(out_valid), 64'd0);
    single_beat("t6_first_beat", 2'd1, 16'h0000,
                pack4(16'hFFF0, 16'h0040, 16'h8000, 16'h0000),
                pack4(16'hFFFE, 16'h0040, 16'hF000, 16'h0000));
    check("t6_zero_count", 64'(zero_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
Parametrised multi-channel activation stage for the CNN datapath. It replaces the single-lane registered ReLU with a vector of CHANNELS signed lanes and four selectable modes: ReLU, leaky ReLU, clipped ReLU and bypass. It runs as a 2-stage valid/ready pipeline, so it sits between the convolution/accumulator output and the pooling stage with full backpressure. It also keeps a saturating count of zero-valued outputs for sparsity monitoring.

Parameters:
DATA_W, 16, lane width; two's-complement signed; MSB is sign
CHANNELS, 4, number of parallel lanes per beat
LEAK_SHIFT, 3, arithmetic right-shift applied to negatives in leaky mode (slope 2^-LEAK_SHIFT)
CNT_W, 16, width of zero-output statistics counter

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
mode  input  2  activation select, sampled with each accepted input beat
clip_max  input  DATA_W  clipped-ReLU ceiling, treated as non-negative; sampled with each accepted beat
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_data  input  CHANNELS*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output
out_data  output  CHANNELS*DATA_W  activated lanes, same packing as in_data
clear_stats  input  1  synchronous clear of zero_count
zero_count  output  CNT_W  saturating count of zero lanes delivered

Behaviour:
- Reset (reset=0, async): s1_valid, s2_valid/out_valid=0; stage data, mode and clip registers=0; out_data=0; zero_count=0. Beats in flight are discarded. Outputs are valid from the first clock edge after release.
- Pipeline:
  - S1 registers in_data, mode and clip_max on the input handshake (in_valid & in_ready).
  - S2 registers the activated result and is out_data.
- Latency: 2 cycles from the input handshake to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Stall rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; there is no skid buffer.
  - A stalled stage holds its data and valid unchanged.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Lane function, per lane, with x the signed lane value from S1:
  - mode 0 ReLU: x<0 -> 0; else x.
  - mode 1 leaky: x<0 -> x>>>LEAK_SHIFT (arithmetic, rounds toward -inf, so -1 stays -1); else x.
  - mode 2 clipped: x<0 -> 0; x>clip_max -> clip_max; else x. Compare signed, with clip_max zero-extended.
  - mode 3 bypass: x unchanged.
- Mode and clip_max travel with their beat. Changing them mid-stream affects only beats accepted afterwards.
- Stats:
  - On each output handshake, add the number of lanes equal to 0 (0..CHANNELS) to zero_count.
  - zero_count saturates at 2^CNT_W-1 and does not wrap.
  - When clear_stats=1, zero_count loads the current cycle's increment (0 if there is no handshake). Clear therefore has priority over the old value but does not lose the concurrent beat.
- If in_valid drops, no beat is inserted. Bubbles propagate and out_valid=0 for the corresponding cycle.

Decomposition:
- Shared package/header holds the mode encodings ACT_RELU=0, ACT_LEAKY=1, ACT_CLIP=2, ACT_BYPASS=3 and the default DATA_W.
- Sub-module activation_lane: purely combinational single-lane function (x, mode, clip_max -> y, is_zero). It is instantiated CHANNELS times via generate.
- The top level owns the pipeline registers, handshake and counter.

Test Plan:
All scenarios use DATA_W=16, CHANNELS=4, LEAK_SHIFT=3.
1. mode 0, lanes {0x8000, 0xFFFF, 0x0000, 0x1234}, out_ready=1 -> 2 cycles later out {0,0,0,0x1234}; zero_count=3.
2. mode 1, lanes {0xFFF8(-8), 0xFFFF(-1), 0xFF00(-256), 0x0010} -> out {0xFFFF, 0xFFFF, 0xFFE0, 0x0010}; zero_count unchanged.
3. mode 2, clip_max=0x0600, lanes {0x0700, 0x0600, 0xF000, 0x0005} -> {0x0600, 0x0600, 0, 0x0005}.
4. Stream of 6 beats with out_ready low for 3 cycles after the 2nd beat:
   - in_ready drops once both stages are full.
   - out_data holds stable while stalled.
   - All 6 beats emerge in order with no loss or duplication.
   - Mode is toggled per beat and each beat uses its own mode.
5. Drive zero lanes until zero_count reaches 0xFFFF, then one more all-zero beat -> zero_count stays 0xFFFF. Then clear_stats together with a 2-zero beat handshake -> zero_count=2.
6. Assert reset while both stages are valid -> out_valid=0, out_data=0 and zero_count=0 immediately (async). After release, the first new beat appears 2 cycles after its acceptance.
